// File: rtl/bram_dma.sv
// bram_dma: block-RAM copy/fill engine driving the initiator side of the on-chip RAM port.
// Latency: copy of N words takes 2N memory cycles (read then write per word), fill takes N, len=0 takes none;
//          done_o pulses for one cycle after the last write. Backpressure: none, the RAM is owned while busy_o is high.
//
// Build option: define BRAM_DMA_FILL_EN to compile in fill mode. When undefined every command
// is a copy, fill_i/fill_data_i are ignored and no fill-constant register exists.
//
// Ports:
//   clk, reset_n_i             clock and synchronous active-low reset
//   start_i                    command strobe, only looked at in IDLE
//   src_addr_i, dst_addr_i     start word addresses (copy source / destination)
//   len_i                      word count 0..2^ADDR_W
//   fill_i, fill_data_i        fill-mode select and fill constant
//   busy_o, done_o             engine busy / one-cycle completion pulse
//   mem_sel_o, mem_wr_en_o,
//   mem_wr_mask_o,
//   mem_address_o, mem_data_o  RAM request signals
//   mem_data_i                 RAM read data, valid the cycle after the read edge
module bram_dma #(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 32
) (
    input  logic                clk,
    input  logic                reset_n_i,
    input  logic                start_i,
    input  logic [ADDR_W-1:0]   src_addr_i,
    input  logic [ADDR_W-1:0]   dst_addr_i,
    input  logic [ADDR_W:0]     len_i,
    input  logic                fill_i,
    input  logic [DATA_W-1:0]   fill_data_i,
    output logic                busy_o,
    output logic                done_o,
    output logic                mem_sel_o,
    output logic                mem_wr_en_o,
    output logic [DATA_W/8-1:0] mem_wr_mask_o,
    output logic [ADDR_W-1:0]   mem_address_o,
    output logic [DATA_W-1:0]   mem_data_o,
    input  logic [DATA_W-1:0]   mem_data_i
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_READ  = 2'd1,
        S_WRITE = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    localparam logic [ADDR_W:0] IDX_ONE = {{ADDR_W{1'b0}}, 1'b1};

    state_t                r_state;
    state_t                w_state_nxt;

    // Latched command; inputs may change freely once accepted.
    logic [ADDR_W-1:0]     r_src;
    logic [ADDR_W-1:0]     r_dst;
    logic [ADDR_W:0]       r_len;
    // One bit wider than an address so a full-memory run (len = 2^ADDR_W) can terminate.
    logic [ADDR_W:0]       r_idx;

    logic [ADDR_W:0]       w_idx_nxt;
    logic                  w_last;
    logic                  w_accept;
    logic                  w_start_fill;
    logic                  w_fill_mode;
    logic [DATA_W-1:0]     w_fill_data;
    logic [ADDR_W-1:0]     w_src_addr;
    logic [ADDR_W-1:0]     w_dst_addr;

    assign w_accept  = (r_state == S_IDLE) && start_i;
    assign w_idx_nxt = r_idx + IDX_ONE;
    assign w_last    = (w_idx_nxt == r_len);

    // Addresses wrap modulo 2^ADDR_W by truncation.
    assign w_src_addr = r_src + r_idx[ADDR_W-1:0];
    assign w_dst_addr = r_dst + r_idx[ADDR_W-1:0];

`ifdef BRAM_DMA_FILL_EN
    logic                  r_fill;
    logic [DATA_W-1:0]     r_fill_data;

    always_ff @(posedge clk) begin
        if (!reset_n_i) begin
            r_fill      <= 1'b0;
            r_fill_data <= '0;
        end else if (w_accept) begin
            r_fill      <= fill_i;
            r_fill_data <= fill_data_i;
        end
    end

    assign w_start_fill = fill_i;
    assign w_fill_mode  = r_fill;
    assign w_fill_data  = r_fill_data;
`else
    // Fill inputs have no function in this build; fold them into a sink.
    logic                  w_unused_fill;
    assign w_unused_fill = fill_i ^ (^fill_data_i);

    assign w_start_fill = 1'b0;
    assign w_fill_mode  = 1'b0;
    assign w_fill_data  = '0;
`endif

    // Command latch and word index.
    always_ff @(posedge clk) begin
        if (!reset_n_i) begin
            r_src <= '0;
            r_dst <= '0;
            r_len <= '0;
            r_idx <= '0;
        end else if (w_accept) begin
            r_src <= src_addr_i;
            r_dst <= dst_addr_i;
            r_len <= len_i;
            r_idx <= '0;
        end else if ((r_state == S_WRITE) && !w_last) begin
            r_idx <= w_idx_nxt;
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (!reset_n_i) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next state and output decode. Everything except copy-mode write data
    // is a function of registered state, index and latched command.
    always_comb begin
        w_state_nxt   = r_state;
        busy_o        = 1'b0;
        done_o        = 1'b0;
        mem_sel_o     = 1'b0;
        mem_wr_en_o   = 1'b0;
        mem_wr_mask_o = '0;
        mem_address_o = '0;
        mem_data_o    = '0;

        unique case (r_state)
            S_IDLE: begin
                if (start_i) begin
                    if (len_i == '0) begin
                        w_state_nxt = S_DONE;
                    end else if (w_start_fill) begin
                        w_state_nxt = S_WRITE;
                    end else begin
                        w_state_nxt = S_READ;
                    end
                end
            end

            S_READ: begin
                busy_o        = 1'b1;
                mem_sel_o     = 1'b1;
                mem_address_o = w_src_addr;
                w_state_nxt   = S_WRITE;
            end

            S_WRITE: begin
                busy_o        = 1'b1;
                mem_sel_o     = 1'b1;
                mem_wr_en_o   = 1'b1;
                mem_wr_mask_o = '1;
                mem_address_o = w_dst_addr;
                // Copy data is the word read in the previous cycle, passed straight through.
                mem_data_o    = w_fill_mode ? w_fill_data : mem_data_i;
                if (w_last) begin
                    w_state_nxt = S_DONE;
                end else if (w_fill_mode) begin
                    w_state_nxt = S_WRITE;
                end else begin
                    w_state_nxt = S_READ;
                end
            end

            S_DONE: begin
                done_o      = 1'b1;
                w_state_nxt = S_IDLE;
            end

            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_bram_dma.sv
`timescale 1ns/1ps
module tb_bram_dma;
    localparam int AW    = 10;
    localparam int DW    = 32;
    localparam int DEPTH = 1 << AW;
`ifdef BRAM_DMA_FILL_EN
    localparam bit FILL_EN = 1'b1;
`else
    localparam bit FILL_EN = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              reset_n_i;
    logic              start_i;
    logic [AW-1:0]     src_addr_i;
    logic [AW-1:0]     dst_addr_i;
    logic [AW:0]       len_i;
    logic              fill_i;
    logic [DW-1:0]     fill_data_i;
    logic              busy_o;
    logic              done_o;
    logic              mem_sel_o;
    logic              mem_wr_en_o;
    logic [DW/8-1:0]   mem_wr_mask_o;
    logic [AW-1:0]     mem_address_o;
    logic [DW-1:0]     mem_data_o;
    logic [DW-1:0]     mem_data_i;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    bram_dma #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .clk           (clk),
        .reset_n_i     (reset_n_i),
        .start_i       (start_i),
        .src_addr_i    (src_addr_i),
        .dst_addr_i    (dst_addr_i),
        .len_i         (len_i),
        .fill_i        (fill_i),
        .fill_data_i   (fill_data_i),
        .busy_o        (busy_o),
        .done_o        (done_o),
        .mem_sel_o     (mem_sel_o),
        .mem_wr_en_o   (mem_wr_en_o),
        .mem_wr_mask_o (mem_wr_mask_o),
        .mem_address_o (mem_address_o),
        .mem_data_o    (mem_data_o),
        .mem_data_i    (mem_data_i)
    );

    // Block RAM model with a preload port; reference memory tracks intended contents.
    logic [DW-1:0] ram     [DEPTH];
    logic [DW-1:0] ref_mem [DEPTH];
    logic          pl_en   = 1'b0;
    logic [AW-1:0] pl_addr = '0;
    logic [DW-1:0] pl_dat  = '0;

    always @(posedge clk) begin
        if (pl_en) begin
            ram[pl_addr] <= pl_dat;
        end else if (mem_sel_o) begin
            if (mem_wr_en_o) begin
                for (int b = 0; b < DW/8; b++)
                    if (mem_wr_mask_o[b]) ram[mem_address_o][b*8 +: 8] <= mem_data_o[b*8 +: 8];
            end else begin
                mem_data_i <= ram[mem_address_o];
            end
        end
    end

    task automatic poke(input int a, input logic [DW-1:0] d);
        @(negedge clk);
        pl_en = 1'b1; pl_addr = AW'(a); pl_dat = d;
        ref_mem[a % DEPTH] = d;
        @(negedge clk);
        pl_en = 1'b0;
    endtask

    task automatic init_ram();
        @(negedge clk);
        pl_en = 1'b1;
        for (int i = 0; i < DEPTH; i++) begin
            pl_addr = AW'(i);
            pl_dat  = $urandom;
            ref_mem[i] = pl_dat;
            @(negedge clk);
        end
        pl_en = 1'b0;
    endtask

    // Reference semantics: ascending word-by-word transfer, addresses modulo DEPTH.
    task automatic apply_ref(input int s, input int d, input int n, input bit f, input logic [DW-1:0] fd);
        for (int i = 0; i < n; i++) begin
            if (FILL_EN && f) ref_mem[(d + i) % DEPTH] = fd;
            else              ref_mem[(d + i) % DEPTH] = ref_mem[(s + i) % DEPTH];
        end
    endtask

    function automatic int exp_done_cyc(input int n, input bit f);
        if (n == 0)            return 1;
        else if (FILL_EN && f) return n + 1;
        else                   return 2 * n + 1;
    endfunction

    task automatic ram_diff(output int cnt, output int first);
        cnt = 0; first = -1;
        for (int i = 0; i < DEPTH; i++)
            if (ram[i] !== ref_mem[i]) begin
                cnt++;
                if (first < 0) first = i;
            end
    endtask

    // Issue one command and observe until a few cycles past done (bounded).
    task automatic run_cmd(input int s, input int d, input int n, input bit f, input logic [DW-1:0] fd,
                           output int done_cyc, output int busy_cnt, output int done_cnt,
                           output int sel_cnt, output int bad_out);
        int cyc;
        int tail;
        done_cyc = -1; busy_cnt = 0; done_cnt = 0; sel_cnt = 0; bad_out = 0; tail = 0; cyc = 0;
        @(negedge clk);
        start_i = 1'b1; src_addr_i = AW'(s); dst_addr_i = AW'(d); len_i = (AW+1)'(n);
        fill_i = f; fill_data_i = fd;
        while (cyc < 2 * DEPTH + 20 && tail < 3) begin
            @(negedge clk);
            cyc++;
            if (cyc == 1) begin
                start_i     = 1'b0;
                src_addr_i  = AW'($urandom);
                dst_addr_i  = AW'($urandom);
                len_i       = (AW+1)'($urandom);
                fill_i      = 1'($urandom);
                fill_data_i = $urandom;
            end
            if (busy_o) busy_cnt++;
            if (mem_sel_o) sel_cnt++;
            if (busy_o !== mem_sel_o) bad_out++;
            if (mem_sel_o && mem_wr_en_o && mem_wr_mask_o !== '1) bad_out++;
            if (!mem_sel_o && (mem_wr_en_o !== 1'b0 || mem_wr_mask_o !== '0 ||
                               mem_address_o !== '0 || mem_data_o !== '0)) bad_out++;
            if (done_o) begin
                done_cnt++;
                if (done_cyc < 0) done_cyc = cyc;
            end
            if (done_cyc >= 0) tail++;
        end
    endtask

    task automatic test_reset();
        reset_n_i = 1'b0; start_i = 1'b1; src_addr_i = '0; dst_addr_i = '0;
        len_i = 11'd5; fill_i = 1'b0; fill_data_i = '0;
        repeat (3) @(negedge clk);
        n_checks++; if (busy_o !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b, expected 0", busy_o); end
        n_checks++; if (done_o !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b, expected 0", done_o); end
        n_checks++; if (mem_sel_o !== 1'b0) begin n_fail++; $display("FAIL reset_sel: got %b, expected 0", mem_sel_o); end
        n_checks++; if (mem_wr_en_o !== 1'b0) begin n_fail++; $display("FAIL reset_wr_en: got %b, expected 0", mem_wr_en_o); end
        n_checks++; if (mem_wr_mask_o !== '0) begin n_fail++; $display("FAIL reset_mask: got %h, expected 0", mem_wr_mask_o); end
        n_checks++; if (mem_address_o !== '0) begin n_fail++; $display("FAIL reset_addr: got %h, expected 0", mem_address_o); end
        n_checks++; if (mem_data_o !== '0) begin n_fail++; $display("FAIL reset_data: got %h, expected 0", mem_data_o); end
        start_i = 1'b0;
        @(negedge clk);
        reset_n_i = 1'b1;
        @(negedge clk);
        n_checks++; if (busy_o !== 1'b0) begin n_fail++; $display("FAIL post_reset_idle: busy %b, expected 0", busy_o); end
    endtask

    task automatic test_copy_basic();
        int dc, bc, dn, sc, bad, diff, first;
        for (int i = 0; i < 4; i++) poke(32'h010 + i, 32'hA0 + i);
        run_cmd(32'h010, 32'h100, 4, 1'b0, '0, dc, bc, dn, sc, bad);
        apply_ref(32'h010, 32'h100, 4, 1'b0, '0);
        for (int i = 0; i < 4; i++) begin
            n_checks++;
            if (ram[32'h100 + i] !== 32'hA0 + i) begin
                n_fail++; $display("FAIL copy_word%0d: got %h, expected %h", i, ram[32'h100 + i], 32'hA0 + i);
            end
        end
        n_checks++; if (bc !== 8) begin n_fail++; $display("FAIL copy_busy_cycles: got %0d, expected 8", bc); end
        n_checks++; if (dc !== 9) begin n_fail++; $display("FAIL copy_done_cycle: got %0d, expected 9", dc); end
        n_checks++; if (dn !== 1) begin n_fail++; $display("FAIL copy_done_pulses: got %0d, expected 1", dn); end
        n_checks++; if (bad !== 0) begin n_fail++; $display("FAIL copy_port_rules: got %0d violations, expected 0", bad); end
        ram_diff(diff, first);
        n_checks++; if (diff !== 0) begin n_fail++; $display("FAIL copy_ram: %0d words differ (first %0d), expected 0", diff, first); end
    endtask

    task automatic test_len_zero();
        int dc, bc, dn, sc, bad, diff, first;
        run_cmd(int'($urandom_range(0, DEPTH-1)), int'($urandom_range(0, DEPTH-1)), 0, 1'b1, 32'h1234_5678,
                dc, bc, dn, sc, bad);
        n_checks++; if (dc !== 1) begin n_fail++; $display("FAIL len0_done_cycle: got %0d, expected 1", dc); end
        n_checks++; if (sc !== 0) begin n_fail++; $display("FAIL len0_sel: got %0d cycles, expected 0", sc); end
        n_checks++; if (bc !== 0) begin n_fail++; $display("FAIL len0_busy: got %0d cycles, expected 0", bc); end
        ram_diff(diff, first);
        n_checks++; if (diff !== 0) begin n_fail++; $display("FAIL len0_ram: %0d words differ (first %0d), expected 0", diff, first); end
    endtask

    task automatic test_overlap();
        int dc, bc, dn, sc, bad, diff, first;
        for (int i = 0; i < 4; i++) poke(i, DW'(i + 1));
        run_cmd(0, 1, 3, 1'b0, '0, dc, bc, dn, sc, bad);
        apply_ref(0, 1, 3, 1'b0, '0);
        for (int i = 0; i < 4; i++) begin
            n_checks++;
            if (ram[i] !== 32'd1) begin n_fail++; $display("FAIL overlap_word%0d: got %h, expected 1", i, ram[i]); end
        end
        ram_diff(diff, first);
        n_checks++; if (diff !== 0) begin n_fail++; $display("FAIL overlap_ram: %0d words differ (first %0d), expected 0", diff, first); end
    endtask

    task automatic test_back_to_back();
        int cyc, d1, d2, dn, b6, diff, first;
        cyc = 0; d1 = -1; d2 = -1; dn = 0; b6 = -1;
        apply_ref(32'h040, 32'h080, 2, 1'b0, '0);
        @(negedge clk);
        start_i = 1'b1; src_addr_i = 10'h040; dst_addr_i = 10'h080; len_i = 11'd2; fill_i = 1'b0;
        while (cyc < 100 && d2 < 0) begin
            @(negedge clk);
            cyc++;
            if (cyc == 1) begin src_addr_i = 10'h0C0; dst_addr_i = 10'h0E0; len_i = 11'd3; end
            if (cyc == 6) b6 = int'(busy_o);
            if (done_o) begin
                dn++;
                if (d1 < 0) begin
                    d1 = cyc;
                    ram_diff(diff, first);
                    n_checks++;
                    if (diff !== 0) begin n_fail++; $display("FAIL b2b_first_only: %0d words differ (first %0d), expected 0", diff, first); end
                end else begin
                    d2 = cyc;
                end
            end
        end
        start_i = 1'b0;
        repeat (3) @(negedge clk);
        apply_ref(32'h0C0, 32'h0E0, 3, 1'b0, '0);
        n_checks++; if (d1 !== 5) begin n_fail++; $display("FAIL b2b_first_done: got %0d, expected 5", d1); end
        n_checks++; if (b6 !== 0) begin n_fail++; $display("FAIL b2b_idle_gap_busy: got %0d, expected 0", b6); end
        n_checks++; if (d2 !== 13) begin n_fail++; $display("FAIL b2b_second_done: got %0d, expected 13", d2); end
        n_checks++; if (dn !== 2) begin n_fail++; $display("FAIL b2b_done_pulses: got %0d, expected 2", dn); end
        ram_diff(diff, first);
        n_checks++; if (diff !== 0) begin n_fail++; $display("FAIL b2b_ram: %0d words differ (first %0d), expected 0", diff, first); end
    endtask

`ifdef BRAM_DMA_FILL_EN
    task automatic test_fill();
        int dc, bc, dn, sc, bad, diff, first;
        int addrs [4];
        addrs = '{32'h3FE, 32'h3FF, 32'h000, 32'h001};
        run_cmd(int'($urandom_range(0, DEPTH-1)), 32'h3FE, 4, 1'b1, 32'hDEADBEEF, dc, bc, dn, sc, bad);
        apply_ref(0, 32'h3FE, 4, 1'b1, 32'hDEADBEEF);
        for (int i = 0; i < 4; i++) begin
            n_checks++;
            if (ram[addrs[i]] !== 32'hDEADBEEF) begin
                n_fail++; $display("FAIL fill_word_%0h: got %h, expected deadbeef", addrs[i], ram[addrs[i]]);
            end
        end
        n_checks++; if (dc !== 5) begin n_fail++; $display("FAIL fill_done_cycle: got %0d, expected 5", dc); end
        n_checks++; if (bc !== 4) begin n_fail++; $display("FAIL fill_busy_cycles: got %0d, expected 4", bc); end
        ram_diff(diff, first);
        n_checks++; if (diff !== 0) begin n_fail++; $display("FAIL fill_ram: %0d words differ (first %0d), expected 0", diff, first); end
    endtask
`endif

    task automatic test_random();
        int dc, bc, dn, sc, bad, diff, first, s, d, n, ed;
        bit f;
        logic [DW-1:0] fd;
        for (int it = 0; it < 10; it++) begin
            s  = int'($urandom_range(0, DEPTH-1));
            d  = int'($urandom_range(0, DEPTH-1));
            n  = (it == 0) ? DEPTH : int'($urandom_range(0, 40));
            f  = 1'($urandom);
            fd = $urandom;
            run_cmd(s, d, n, f, fd, dc, bc, dn, sc, bad);
            apply_ref(s, d, n, f, fd);
            ed = exp_done_cyc(n, f);
            n_checks++; if (dc !== ed) begin n_fail++; $display("FAIL rand%0d_done_cycle: got %0d, expected %0d", it, dc, ed); end
            n_checks++; if (bc !== ed - 1) begin n_fail++; $display("FAIL rand%0d_busy: got %0d, expected %0d", it, bc, ed - 1); end
            n_checks++; if (dn !== 1) begin n_fail++; $display("FAIL rand%0d_done_pulses: got %0d, expected 1", it, dn); end
            n_checks++; if (bad !== 0) begin n_fail++; $display("FAIL rand%0d_port_rules: got %0d, expected 0", it, bad); end
            ram_diff(diff, first);
            n_checks++; if (diff !== 0) begin n_fail++; $display("FAIL rand%0d_ram: %0d words differ (first %0d), expected 0", it, diff, first); end
        end
    endtask

    // Reset asserted during the write of word 2 of an 8-word transfer.
    task automatic test_reset_mid();
        int cyc, wcyc, dn, sc_after, diff, first;
        logic [DW-1:0] old_w [8];
        logic [DW-1:0] new_w [8];
        logic [DW-1:0] fd;
        fd = 32'hC0DE_0000 | DW'($urandom_range(0, 65535));
        wcyc = FILL_EN ? 3 : 6;
        for (int i = 0; i < 8; i++) begin
            old_w[i] = ref_mem[32'h200 + i];
            new_w[i] = FILL_EN ? fd : ref_mem[32'h300 + i];
        end
        cyc = 0; dn = 0; sc_after = 0;
        @(negedge clk);
        start_i = 1'b1; src_addr_i = 10'h300; dst_addr_i = 10'h200; len_i = 11'd8;
        fill_i = FILL_EN; fill_data_i = fd;
        while (cyc < wcyc + 10) begin
            @(negedge clk);
            cyc++;
            if (cyc == 1) start_i = 1'b0;
            if (done_o) dn++;
            if (cyc > wcyc && mem_sel_o) sc_after++;
            if (cyc == wcyc) reset_n_i = 1'b0;
            if (cyc == wcyc + 1) begin
                n_checks++;
                if ({busy_o, done_o, mem_sel_o, mem_wr_en_o} !== 4'b0 || mem_wr_mask_o !== '0 ||
                    mem_address_o !== '0 || mem_data_o !== '0) begin
                    n_fail++;
                    $display("FAIL rst_mid_outputs: got busy=%b done=%b sel=%b we=%b mask=%h addr=%h data=%h, expected all 0",
                             busy_o, done_o, mem_sel_o, mem_wr_en_o, mem_wr_mask_o, mem_address_o, mem_data_o);
                end
                reset_n_i = 1'b1;
            end
        end
        n_checks++; if (dn !== 0) begin n_fail++; $display("FAIL rst_mid_done: got %0d pulses, expected 0", dn); end
        n_checks++; if (sc_after !== 0) begin n_fail++; $display("FAIL rst_mid_access_after: got %0d, expected 0", sc_after); end
        n_checks++;
        if (ram[32'h202] !== old_w[2] && ram[32'h202] !== new_w[2]) begin
            n_fail++; $display("FAIL rst_mid_word2: got %h, expected %h or %h", ram[32'h202], old_w[2], new_w[2]);
        end
        ref_mem[32'h200] = new_w[0];
        ref_mem[32'h201] = new_w[1];
        ref_mem[32'h202] = (ram[32'h202] === new_w[2]) ? new_w[2] : old_w[2];
        ram_diff(diff, first);
        n_checks++; if (diff !== 0) begin n_fail++; $display("FAIL rst_mid_ram: %0d words differ (first %0d), expected 0", diff, first); end
    endtask

    initial begin
        test_reset();
        init_ram();
        test_copy_basic();
        test_len_zero();
        test_overlap();
        test_back_to_back();
`ifdef BRAM_DMA_FILL_EN
        test_fill();
`endif
        test_random();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
